wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width.
REQ-002 Parameter ADDR_W, default 3, register address width (2**ADDR_W registers).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; ports as follows.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable_wb  input  1  capture strobe for the ALU-side inputs.
REQ-007 alu_result  input  DATA_W  result from the ALU stage.
REQ-008 OVF  input  1  ALU overflow for alu_result.
REQ-009 destReg_addr  input  ADDR_W  destination register.
REQ-010 we  input  1  write request for the destination register.
REQ-011 rd_addr_a / rd_addr_b  input  ADDR_W each  read-port addresses.
REQ-012 ovf_clear  input  1  clears the sticky overflow flag.
REQ-013 rd_data_a / rd_data_b  output  DATA_W each  combinational read data.
REQ-014 wb_we_output / wb_addr_output / wb_data_output  output  1/ADDR_W/DATA_W  registered commit: commit flag, address, data.
REQ-015 ovf_sticky  output  1  sticky overflow flag.
REQ-016 retire_count  output  16  count of committed writes.

Function
REQ-017 On a clock edge with enable_wb=1, the stage SHALL capture {alu_result, OVF, destReg_addr, we} and set q_valid=1; with enable_wb=0 it SHALL hold data and set q_valid=0.
REQ-018 commit SHALL equal q_valid & q_we & ~q_ovf; wb_we_output=commit, wb_addr_output=q_addr, wb_data_output=q_data.
REQ-019 On the edge after capture, when commit=1, regfile[q_addr] SHALL be written with q_data (total latency: input to visible register = 2 edges).
REQ-020 An overflowing result (q_ovf=1) SHALL never be written to the register file.
REQ-021 rd_data_a/b SHALL be combinational reads of regfile at rd_addr_a/b; both ports may address the same register.
REQ-022 ovf_sticky SHALL set on the edge where q_valid & q_we & q_ovf, clear on the edge where ovf_clear=1; set SHALL win when both coincide.
REQ-023 retire_count SHALL increment by 1 on each edge where commit=1, wrapping 0xFFFF -> 0x0000.
REQ-024 Consecutive captures to the same address SHALL commit in order; last writer wins.

Reset
REQ-025 reset=1 SHALL asynchronously clear q_valid, q_data, q_ovf, q_addr, q_we, all regfile entries, ovf_sticky, and retire_count to 0.
REQ-026 A capture or commit in flight at reset assertion SHALL be discarded; no write occurs.

Configuration
REQ-027 Macro WB_BYPASS_EN defined: when commit=1 and rd_addr_x==q_addr, rd_data_x SHALL return q_data (same-cycle forwarding).
REQ-028 WB_BYPASS_EN undefined: rd_data_x SHALL return the stored value only; the new value is visible the cycle after commit.

Structure
REQ-029 DATA_W/ADDR_W defaults and the commit-record field layout SHALL live in the shared pipeline package.
REQ-030 The register array SHALL be a sub-module named regfile (one write port, two combinational read ports, async reset); pipeline register, commit logic, bypass, sticky flag and counter SHALL be in wb_stage.

Verification
REQ-031 Reset, then enable_wb=1, alu_result=0x1234, destReg_addr=5, we=1, OVF=0 -> wb_we_output=1 after edge 1; rd_addr_a=5 reads 0x1234 after edge 2; retire_count=1.
REQ-032 alu_result=0x7FFF, OVF=1, we=1, addr 2 -> no write, reg 2 stays 0, ovf_sticky=1, retire_count unchanged; ovf_clear with a second overflow in the same cycle -> ovf_sticky remains 1.
REQ-033 enable_wb held 0 for 3 cycles after one capture -> exactly one commit, retire_count +1 only.
REQ-034 With WB_BYPASS_EN: commit 0xBEEF to reg 3 with rd_addr_b=3 -> rd_data_b=0xBEEF in the commit cycle; without the macro -> old value in the commit cycle, 0xBEEF in the next.
REQ-035 Preload retire_count to 0xFFFF via 65535 commits, one more commit -> 0x0000; assert reset mid-capture -> all outputs 0, no write.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared pipeline package for the write-back stage: default widths and commit-record layout.
package wb_stage_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned ADDR_W_DEF = 3;
   localparam int unsigned CNT_W      = 16;

   // Commit record as captured by the pipeline register: {data, ovf, addr, we}
   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  ovf;
      logic [ADDR_W_DEF-1:0] addr;
      logic                  we;
   } wb_rec_t;

endpackage

// File: rtl/wb_stage_if.sv
// Bus interface of the write-back stage: ALU-side capture, read ports, commit and status.
interface wb_stage_if
   import wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

   logic              enable_wb;
   logic [DATA_W-1:0] alu_result;
   logic              OVF;
   logic [ADDR_W-1:0] destReg_addr;
   logic              we;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic              ovf_clear;
   logic [DATA_W-1:0] rd_data_a;
   logic [DATA_W-1:0] rd_data_b;
   logic              wb_we_output;
   logic [ADDR_W-1:0] wb_addr_output;
   logic [DATA_W-1:0] wb_data_output;
   logic              ovf_sticky;
   logic [CNT_W-1:0]  retire_count;

   // Driver side (ALU stage / testbench)
   modport master (
      output enable_wb, alu_result, OVF, destReg_addr, we,
      output rd_addr_a, rd_addr_b, ovf_clear,
      input  rd_data_a, rd_data_b,
      input  wb_we_output, wb_addr_output, wb_data_output,
      input  ovf_sticky, retire_count
   );

   // Write-back stage side
   modport slave (
      input  enable_wb, alu_result, OVF, destReg_addr, we,
      input  rd_addr_a, rd_addr_b, ovf_clear,
      output rd_data_a, rd_data_b,
      output wb_we_output, wb_addr_output, wb_data_output,
      output ovf_sticky, retire_count
   );

endinterface

// File: rtl/wb_stage_regfile.sv
// Register array: one write port, two combinational read ports, async active-high reset.
module regfile
   import wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Next-state of the array: hold, except the addressed entry on a write
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (we) begin
         mem_d[waddr] = wdata;
      end
   end

   // Array storage with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
      end
   end

   // Combinational read ports; both may address the same entry
   always_comb begin
      rdata_a = mem_q[raddr_a];
      rdata_b = mem_q[raddr_b];
   end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: capture register, commit gating, sticky overflow, retire counter,
// and the register file. Optional same-cycle read forwarding under macro WB_BYPASS_EN.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input logic       clk,
   input logic       reset,
   wb_stage_if.slave bus
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic              ovf_q,   ovf_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic              we_q,    we_d;
   logic              sticky_q, sticky_d;
   logic [CNT_W-1:0]  count_q,  count_d;

   logic              commit;
   logic              ovf_set;
   logic [DATA_W-1:0] rf_data_a;
   logic [DATA_W-1:0] rf_data_b;

   // Capture path, commit decision, sticky flag and retire counter next-state
   always_comb begin
      valid_d  = 1'b0;
      data_d   = data_q;
      ovf_d    = ovf_q;
      addr_d   = addr_q;
      we_d     = we_q;
      if (bus.enable_wb) begin
         valid_d = 1'b1;
         data_d  = bus.alu_result;
         ovf_d   = bus.OVF;
         addr_d  = bus.destReg_addr;
         we_d    = bus.we;
      end

      commit  = valid_q & we_q & ~ovf_q;
      ovf_set = valid_q & we_q & ovf_q;

      sticky_d = sticky_q;
      if (ovf_set) begin
         sticky_d = 1'b1;
      end else if (bus.ovf_clear) begin
         sticky_d = 1'b0;
      end

      count_d = count_q + CNT_W'(commit);
   end

   // Pipeline register and status state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         ovf_q    <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         sticky_q <= 1'b0;
         count_q  <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         ovf_q    <= ovf_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
      end
   end

   regfile #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_regfile (
      .clk     (clk),
      .reset   (reset),
      .we      (commit),
      .waddr   (addr_q),
      .wdata   (data_q),
      .raddr_a (bus.rd_addr_a),
      .raddr_b (bus.rd_addr_b),
      .rdata_a (rf_data_a),
      .rdata_b (rf_data_b)
   );

   // Read data: stored value, optionally forwarded from the committing record
   always_comb begin
      bus.rd_data_a = rf_data_a;
      bus.rd_data_b = rf_data_b;
`ifdef WB_BYPASS_EN
      if (commit && (bus.rd_addr_a == addr_q)) begin
         bus.rd_data_a = data_q;
      end
      if (commit && (bus.rd_addr_b == addr_q)) begin
         bus.rd_data_b = data_q;
      end
`endif
   end

   // Commit and status outputs
   always_comb begin
      bus.wb_we_output   = commit;
      bus.wb_addr_output = addr_q;
      bus.wb_data_output = data_q;
      bus.ovf_sticky     = sticky_q;
      bus.retire_count   = count_q;
   end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard testbench for wb_stage: stimulus pushes expected commits, a negedge monitor pops them.
module tb_wb_stage;
   import wb_stage_pkg::*;

`ifdef WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk;
   logic reset;

   wb_stage_if #(.DATA_W(DATA_W_DEF), .ADDR_W(ADDR_W_DEF)) bus ();

   wb_stage #(.DATA_W(DATA_W_DEF), .ADDR_W(ADDR_W_DEF)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   wb_rec_t     exp_q[$];
   logic [15:0] exp_count = 16'h0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one capture for one edge; expected commits go to the scoreboard
   task automatic drive(input logic [15:0] d, input logic ovf, input logic [2:0] a,
                        input logic w, input bit track);
      wb_rec_t r;
      bus.enable_wb    = 1'b1;
      bus.alu_result   = d;
      bus.OVF          = ovf;
      bus.destReg_addr = a;
      bus.we           = w;
      if (track && w && !ovf) begin
         r.data = d; r.ovf = 1'b0; r.addr = a; r.we = 1'b1;
         exp_q.push_back(r);
         exp_count = exp_count + 16'd1;
      end
      @(posedge clk); #1;
      bus.enable_wb = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: every presented commit must match the oldest expected record
   always @(negedge clk) begin
      if (!reset && bus.wb_we_output) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_commit_addr", 32'(bus.wb_addr_output), 32'hDEAD);
         end else begin
            wb_rec_t e;
            e = exp_q.pop_front();
            chk("commit_addr", 32'(bus.wb_addr_output), 32'(e.addr));
            chk("commit_data", 32'(bus.wb_data_output), 32'(e.data));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset            = 1'b1;
      bus.enable_wb    = 1'b0;
      bus.alu_result   = '0;
      bus.OVF          = 1'b0;
      bus.destReg_addr = '0;
      bus.we           = 1'b0;
      bus.rd_addr_a    = '0;
      bus.rd_addr_b    = '0;
      bus.ovf_clear    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_we",     32'(bus.wb_we_output), 32'h0);
      chk("rst_count",  32'(bus.retire_count), 32'h0);
      chk("rst_sticky", 32'(bus.ovf_sticky),   32'h0);
      for (int i = 0; i < 8; i++) begin
         bus.rd_addr_a = 3'(i);
         #1;
         chk("rst_reg", 32'(bus.rd_data_a), 32'h0);
      end
      reset = 1'b0;
      idle(1);

      // Basic commit: visible on the commit outputs after edge 1, in the register after edge 2
      bus.rd_addr_a = 3'd5;
      drive(16'h1234, 1'b0, 3'd5, 1'b1, 1'b1);
      chk("c1_we",   32'(bus.wb_we_output),   32'h1);
      chk("c1_addr", 32'(bus.wb_addr_output), 32'h5);
      chk("c1_data", 32'(bus.wb_data_output), 32'h1234);
      chk("c1_pre_read", 32'(bus.rd_data_a), BYPASS ? 32'h1234 : 32'h0);
      idle(1);
      chk("c1_read",  32'(bus.rd_data_a),    32'h1234);
      chk("c1_count", 32'(bus.retire_count), 32'h1);

      // Overflow: never written, sets sticky, counter unchanged
      bus.rd_addr_a = 3'd2;
      drive(16'h7FFF, 1'b1, 3'd2, 1'b1, 1'b1);
      chk("ovf_we", 32'(bus.wb_we_output), 32'h0);
      idle(1);
      chk("ovf_sticky", 32'(bus.ovf_sticky),   32'h1);
      chk("ovf_count",  32'(bus.retire_count), 32'h1);
      chk("ovf_reg2",   32'(bus.rd_data_a),    32'h0);
      bus.ovf_clear = 1'b1;
      idle(1);
      bus.ovf_clear = 1'b0;
      chk("clr_sticky", 32'(bus.ovf_sticky), 32'h0);
      drive(16'h7FFF, 1'b1, 3'd2, 1'b1, 1'b1);
      bus.ovf_clear = 1'b1;
      idle(1);
      bus.ovf_clear = 1'b0;
      chk("set_wins_sticky", 32'(bus.ovf_sticky), 32'h1);
      bus.ovf_clear = 1'b1;
      idle(1);
      bus.ovf_clear = 1'b0;
      // Overflow without a write request leaves sticky alone
      drive(16'h0100, 1'b1, 3'd2, 1'b0, 1'b1);
      idle(1);
      chk("ovf_nowe_sticky", 32'(bus.ovf_sticky), 32'h0);

      // One capture then enable low for three cycles: exactly one commit
      bus.rd_addr_a = 3'd1;
      drive(16'h00AA, 1'b0, 3'd1, 1'b1, 1'b1);
      idle(3);
      chk("hold_count", 32'(bus.retire_count), 32'(exp_count));
      chk("hold_reg1",  32'(bus.rd_data_a),    32'h00AA);

      // Back-to-back writes to one register: last writer wins, dual-port same address
      drive(16'h0001, 1'b0, 3'd4, 1'b1, 1'b1);
      drive(16'h0002, 1'b0, 3'd4, 1'b1, 1'b1);
      drive(16'h0003, 1'b0, 3'd4, 1'b1, 1'b1);
      bus.rd_addr_a = 3'd4;
      bus.rd_addr_b = 3'd4;
      idle(2);
      chk("lww_a", 32'(bus.rd_data_a), 32'h0003);
      chk("lww_b", 32'(bus.rd_data_b), 32'h0003);
      chk("lww_count", 32'(bus.retire_count), 32'(exp_count));

      // Forwarding behaviour in the commit cycle
      drive(16'h1111, 1'b0, 3'd3, 1'b1, 1'b1);
      idle(2);
      bus.rd_addr_b = 3'd3;
      drive(16'hBEEF, 1'b0, 3'd3, 1'b1, 1'b1);
      chk("byp_commit_cycle", 32'(bus.rd_data_b), BYPASS ? 32'hBEEF : 32'h1111);
      idle(1);
      chk("byp_next_cycle", 32'(bus.rd_data_b), 32'hBEEF);

      // Counter wrap: fill to 0xFFFF with continuous commits, then one more
      n = 65535 - int'(exp_count);
      for (int i = 0; i < n; i++) begin
         drive(16'(i), 1'b0, 3'(i % 8), 1'b1, 1'b1);
      end
      idle(2);
      chk("cnt_ffff", 32'(bus.retire_count), 32'h0000FFFF);
      drive(16'hC0DE, 1'b0, 3'd6, 1'b1, 1'b1);
      idle(2);
      chk("cnt_wrap", 32'(bus.retire_count), 32'h0);

      // Reset with a commit in flight: everything clears, no write lands
      drive(16'hFFFF, 1'b1, 3'd0, 1'b1, 1'b1);
      idle(1);
      chk("pre_rst_sticky", 32'(bus.ovf_sticky), 32'h1);
      bus.enable_wb    = 1'b1;
      bus.alu_result   = 16'h5555;
      bus.OVF          = 1'b0;
      bus.destReg_addr = 3'd7;
      bus.we           = 1'b1;
      @(posedge clk); #2;
      reset = 1'b1;
      bus.enable_wb = 1'b0;
      #1;
      chk("mid_rst_we",     32'(bus.wb_we_output),   32'h0);
      chk("mid_rst_addr",   32'(bus.wb_addr_output), 32'h0);
      chk("mid_rst_data",   32'(bus.wb_data_output), 32'h0);
      chk("mid_rst_sticky", 32'(bus.ovf_sticky),     32'h0);
      chk("mid_rst_count",  32'(bus.retire_count),   32'h0);
      for (int i = 0; i < 8; i++) begin
         bus.rd_addr_a = 3'(i);
         bus.rd_addr_b = 3'(7 - i);
         #1;
         chk("mid_rst_reg_a", 32'(bus.rd_data_a), 32'h0);
         chk("mid_rst_reg_b", 32'(bus.rd_data_b), 32'h0);
      end
      #20;
      reset = 1'b0;
      exp_count = 16'h0000;
      bus.rd_addr_a = 3'd7;
      idle(2);
      chk("post_rst_reg7",  32'(bus.rd_data_a),    32'h0);
      chk("post_rst_count", 32'(bus.retire_count), 32'h0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
